wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum number of cycles a strobed transfer waits for a slave ack.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on a timeout.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports mN_wb_cyc_i, mN_wb_stb_i, mN_wb_we_i (N=0,1), input, 1 bit each: master N Wishbone cycle, strobe and write-enable.
REQ-007 SHALL have port mN_wb_sel_i, input, 4 bits: master N byte enables.
REQ-008 SHALL have ports mN_wb_adr_i and mN_wb_dat_i, input, 32 bits each: master N address and write data.
REQ-009 SHALL have port mN_wb_dat_o, output, 32 bits: read data to master N.
REQ-010 SHALL have ports mN_wb_ack_o and mN_wb_err_o, output, 1 bit each: master N acknowledge and timeout-error flag.
REQ-011 SHALL have ports s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, output, 1 bit each: shared slave-side cycle, strobe and write-enable (toward the interconnect).
REQ-012 SHALL have port s_wb_sel_o, output, 4 bits: slave-side byte enables.
REQ-013 SHALL have ports s_wb_adr_o and s_wb_dat_o, output, 32 bits each: slave-side address and write data.
REQ-014 SHALL have ports s_wb_dat_i, input, 32 bits, and s_wb_ack_i, input, 1 bit: slave-side read data and acknowledge.
REQ-015 SHALL have port timeout_irq_o, output, 1 bit: one-cycle pulse on each timeout.

Function
REQ-016 SHALL define the request of master N as reqN = mN_wb_cyc_i & mN_wb_stb_i.
REQ-017 SHALL implement the states IDLE, GNT0, GNT1 and TOUT.
REQ-018 SHALL, in IDLE, move to GNTn on the next edge when only reqn is asserted.
REQ-019 SHALL, in IDLE with req0 and req1 both asserted, grant the master that is not last_grant (round-robin).
REQ-020 SHALL grant with one cycle of latency: a request seen in IDLE at cycle T drives s_wb_cyc_o at T+1.
REQ-021 SHALL, in GNTn, drive the slave-side outputs combinationally from master n.
REQ-022 SHALL, in GNTn, pass s_wb_ack_i and s_wb_dat_i combinationally to master n.
REQ-023 SHALL hold mN_wb_ack_o=0 and mN_wb_dat_o=0 for any master not granted.
REQ-024 SHALL hold the grant in GNTn while mn_wb_cyc_i=1, so multi-beat cycles are not interrupted.
REQ-025 SHALL, when mn_wb_cyc_i falls, return to IDLE, update last_grant=n and drive the slave-side outputs to 0.
REQ-026 SHALL, if the owner drops cyc in the same cycle the other master requests, pass through IDLE for one cycle; the next grant comes two cycles after the drop.
REQ-027 SHALL clear the timeout counter on entering GNTn, on each s_wb_ack_i, and whenever the owner's stb=0.
REQ-028 SHALL increment the timeout counter, saturating at 8 bits, while the owner's stb=1 and no ack arrives.
REQ-029 SHALL enter TOUT when the counter reaches TIMEOUT_CYC.
REQ-030 SHALL, in TOUT (one cycle), drive s_wb_cyc_o and s_wb_stb_o to 0.
REQ-031 SHALL, in TOUT, assert mn_wb_ack_o, mn_wb_err_o and timeout_irq_o for that cycle, with mn_wb_dat_o=ERR_DATA.
REQ-032 SHALL leave TOUT for GNTn if mn_wb_cyc_i is still high, otherwise for IDLE.
REQ-033 SHALL ignore a late s_wb_ack_i that arrives while in IDLE or TOUT.

Reset
REQ-034 SHALL, on wb_rst_i assertion at any time (mid-transfer included), set state=IDLE, last_grant=1 (so m0 wins the first tie) and the counter to 0.
REQ-035 SHALL hold all outputs at 0 while wb_rst_i is asserted.
REQ-036 SHALL arbitrate on the first clock edge after wb_rst_i is released.

Structure
REQ-037 SHALL place the state enum, the default TIMEOUT_CYC and the default ERR_DATA in the shared package wb_arb_pkg.
REQ-038 SHALL implement the saturating timeout counter as sub-module wb_arb_timeout (inputs clear, count; output expired).

Verification
REQ-039 SHALL cover a single m0 read of 0x30000004 with the slave acking at +2 cycles -> s_wb_cyc_o rises 1 cycle after req0; m0 gets ack and data 0x12345678; m1 ack stays 0.
REQ-040 SHALL cover req0 and req1 asserted in the same cycle after reset, repeated 3 times -> grant order m0, m1, m0.
REQ-041 SHALL cover a 4-beat m1 burst while m0 requests -> m0 is not granted until m1 drops cyc, then granted exactly 2 cycles later.
REQ-042 SHALL cover a slave that never acks with TIMEOUT_CYC=16 -> at cycle 16 of stb: ack=1, err=1, dat=0xDEADBEEF, timeout_irq_o pulses once, s_wb_cyc_o low for that cycle.
REQ-043 SHALL cover wb_rst_i asserted asynchronously mid-transfer in GNT1 -> all outputs 0 immediately; after release a tie grants m0 first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF    = 32'hDEAD_BEEF;

  // Arbiter states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;
  localparam logic [1:0] ST_TOUT = 2'd3;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Saturating wait counter; expired fires on the edge the count reaches LIMIT.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = count && (cnt >= LAST);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant, cycle-locked ownership, ack timeout.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  output logic        timeout_irq_o
);

  logic [1:0] state, state_nx;
  logic       own, own_nx;
  logic       last_grant, last_grant_nx;
  logic       req0, req1;
  logic       own_cyc, own_stb;
  logic       in_gnt;
  logic       tmo_clear, tmo_count, tmo_expired;
  wb_req_t    own_req;

  assign req0    = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1    = m1_wb_cyc_i & m1_wb_stb_i;
  assign own_cyc = own ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign own_stb = own ? m1_wb_stb_i : m0_wb_stb_i;
  assign own_req = own ? {m1_wb_we_i, m1_wb_sel_i, m1_wb_adr_i, m1_wb_dat_i}
                       : {m0_wb_we_i, m0_wb_sel_i, m0_wb_adr_i, m0_wb_dat_i};

  // Count only while the owner strobes without an ack; anything else clears.
  assign in_gnt    = (state == ST_GNT0) || (state == ST_GNT1);
  assign tmo_count = in_gnt && own_stb && !s_wb_ack_i;
  assign tmo_clear = !tmo_count;

  wb_arb_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (tmo_clear),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      own        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      own        <= own_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    own_nx        = own;
    last_grant_nx = last_grant;
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = '0;
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m0_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    m1_wb_dat_o   = '0;
    timeout_irq_o = 1'b0;

    case (state)
      ST_IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (req0 && (!req1 || last_grant)) begin
          state_nx = ST_GNT0;
          own_nx   = 1'b0;
        end else if (req1) begin
          state_nx = ST_GNT1;
          own_nx   = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (own_cyc) begin
          s_wb_cyc_o = 1'b1;
          s_wb_stb_o = own_stb;
          s_wb_we_o  = own_req.we;
          s_wb_sel_o = own_req.sel;
          s_wb_adr_o = own_req.adr;
          s_wb_dat_o = own_req.dat;
        end
        if (own) begin
          m1_wb_ack_o = s_wb_ack_i;
          m1_wb_dat_o = s_wb_dat_i;
        end else begin
          m0_wb_ack_o = s_wb_ack_i;
          m0_wb_dat_o = s_wb_dat_i;
        end
        if (!own_cyc) begin
          state_nx      = ST_IDLE;
          last_grant_nx = own;
        end else if (tmo_expired) begin
          state_nx = ST_TOUT;
        end
      end
      ST_TOUT: begin
        timeout_irq_o = 1'b1;
        if (own) begin
          m1_wb_ack_o = 1'b1;
          m1_wb_err_o = 1'b1;
          m1_wb_dat_o = ERR_DATA;
        end else begin
          m0_wb_ack_o = 1'b1;
          m0_wb_err_o = 1'b1;
          m0_wb_dat_o = ERR_DATA;
        end
        if (own_cyc) begin
          state_nx = own ? ST_GNT1 : ST_GNT0;
        end else begin
          state_nx      = ST_IDLE;
          last_grant_nx = own;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios plus random traffic against a bus-level model.
module tb_wb_master_arbiter;

  localparam int          TCYC = 16;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam logic [31:0] A0   = 32'h1000_0000;
  localparam logic [31:0] A1   = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat[2];
  logic [31:0] s_rdat;
  logic        s_ack;

  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack, m0_err, m1_err, irq;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;

  int n_chk = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int base = 0;

  // Bus-level model: who owns the bus, whether a timeout is being reported, wait length.
  int owner = -1;
  int last  = 1;
  int waitc = 0;
  bit tout  = 1'b0;
  bit dead  = 1'b0;

  logic [31:0] tie_exp [3] = '{A0, A1, A0};

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .TIMEOUT_CYC (TCYC),
    .ERR_DATA    (ERR)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .m0_wb_cyc_i   (m_cyc[0]),
    .m0_wb_stb_i   (m_stb[0]),
    .m0_wb_we_i    (m_we[0]),
    .m0_wb_sel_i   (m_sel[0]),
    .m0_wb_adr_i   (m_adr[0]),
    .m0_wb_dat_i   (m_wdat[0]),
    .m0_wb_dat_o   (m0_rdat),
    .m0_wb_ack_o   (m0_ack),
    .m0_wb_err_o   (m0_err),
    .m1_wb_cyc_i   (m_cyc[1]),
    .m1_wb_stb_i   (m_stb[1]),
    .m1_wb_we_i    (m_we[1]),
    .m1_wb_sel_i   (m_sel[1]),
    .m1_wb_adr_i   (m_adr[1]),
    .m1_wb_dat_i   (m_wdat[1]),
    .m1_wb_dat_o   (m1_rdat),
    .m1_wb_ack_o   (m1_ack),
    .m1_wb_err_o   (m1_err),
    .s_wb_cyc_o    (s_cyc),
    .s_wb_stb_o    (s_stb),
    .s_wb_we_o     (s_we),
    .s_wb_sel_o    (s_sel),
    .s_wb_adr_o    (s_adr),
    .s_wb_dat_o    (s_wdat),
    .s_wb_dat_i    (s_rdat),
    .s_wb_ack_i    (s_ack),
    .timeout_irq_o (irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic outs_any();
    return |{s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat, m0_rdat, m1_rdat,
             m0_ack, m1_ack, m0_err, m1_err, irq};
  endfunction

  task automatic drive(input int n, input bit cyc, input bit stb, input bit we, input logic [31:0] adr);
    m_cyc[n]  = cyc;
    m_stb[n]  = stb;
    m_we[n]   = we;
    m_adr[n]  = adr;
    m_sel[n]  = 4'hF;
    m_wdat[n] = adr ^ 32'h5555_AAAA;
  endtask

  // Compare every output against what the model says the bus should show now.
  task automatic settle();
    logic [6:0]  e_sctl;
    logic [31:0] e_sadr, e_sdat, e_d0, e_d1;
    logic [1:0]  e_a0, e_a1;
    logic        e_irq;
    #1;
    e_sctl = '0; e_sadr = '0; e_sdat = '0; e_d0 = '0; e_d1 = '0;
    e_a0 = '0; e_a1 = '0; e_irq = 1'b0;
    if (!rst && tout) begin
      e_irq = 1'b1;
      if (owner == 0) begin e_a0 = 2'b11; e_d0 = ERR; end
      else begin e_a1 = 2'b11; e_d1 = ERR; end
    end else if (!rst && owner >= 0) begin
      if (m_cyc[1'(owner)]) begin
        e_sctl = {1'b1, m_stb[1'(owner)], m_we[1'(owner)], m_sel[1'(owner)]};
        e_sadr = m_adr[1'(owner)];
        e_sdat = m_wdat[1'(owner)];
      end
      if (owner == 0) begin e_a0 = {s_ack, 1'b0}; e_d0 = s_rdat; end
      else begin e_a1 = {s_ack, 1'b0}; e_d1 = s_rdat; end
    end
    chk("s_ctl",  64'({s_cyc, s_stb, s_we, s_sel}), 64'(e_sctl));
    chk("s_adr",  64'(s_adr),  64'(e_sadr));
    chk("s_wdat", 64'(s_wdat), 64'(e_sdat));
    chk("m0_ae",  64'({m0_ack, m0_err}), 64'(e_a0));
    chk("m1_ae",  64'({m1_ack, m1_err}), 64'(e_a1));
    chk("m0_dat", 64'(m0_rdat), 64'(e_d0));
    chk("m1_dat", 64'(m1_rdat), 64'(e_d1));
    chk("irq",    64'(irq), 64'(e_irq));
    if (irq) irq_cnt++;
  endtask

  // Apply the arbitration rules to this cycle's inputs, then move to the next cycle.
  task automatic advance();
    bit r0, r1;
    r0 = m_cyc[0] & m_stb[0];
    r1 = m_cyc[1] & m_stb[1];
    if (rst) begin
      owner = -1; last = 1; waitc = 0; tout = 1'b0;
    end else if (tout) begin
      tout = 1'b0; waitc = 0;
      if (!m_cyc[1'(owner)]) begin last = owner; owner = -1; end
    end else if (owner < 0) begin
      waitc = 0;
      if (r0 && r1) owner = 1 - last;
      else if (r0) owner = 0;
      else if (r1) owner = 1;
    end else if (!m_cyc[1'(owner)]) begin
      last = owner; owner = -1; waitc = 0;
    end else if (m_stb[1'(owner)] && !s_ack) begin
      waitc++;
      if (waitc >= TCYC) tout = 1'b1;
    end else begin
      waitc = 0;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_ack = 1'b0; s_rdat = '0;
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_zero", 64'(outs_any()), 64'(0));

    // Single m0 read, slave acks two cycles after the request.
    drive(0, 1, 1, 0, 32'h3000_0004);
    settle(); chk("pre_gnt", 64'(s_cyc), 64'(0)); advance();
    settle(); chk("gnt_lat", 64'(s_cyc), 64'(1)); chk("rd_adr", 64'(s_adr), 64'(32'h3000_0004)); advance();
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    settle();
    chk("rd_ack", 64'(m0_ack), 64'(1));
    chk("rd_dat", 64'(m0_rdat), 64'(32'h1234_5678));
    chk("rd_m1_ack", 64'(m1_ack), 64'(0));
    advance();
    s_ack = 1'b0;
    drive(0, 0, 0, 0, '0);
    step(); step();

    // Three simultaneous-request rounds after reset alternate m0, m1, m0.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive(0, 1, 1, 0, A0);
      drive(1, 1, 1, 1, A1);
      step();
      settle(); chk("tie_gnt", 64'(s_adr), 64'(tie_exp[r])); advance();
      drive(0, 0, 0, 0, '0);
      drive(1, 0, 0, 0, '0);
      step(); step();
    end

    // m1 four-beat burst holds off m0 until cyc drops; m0 granted two cycles later.
    drive(1, 1, 1, 1, A1);
    step();
    drive(0, 1, 1, 0, A0);
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_adr[1] = A1 + 32'(4 * b);
      settle();
      chk("burst_own", 64'(s_adr), 64'(A1 + 32'(4 * b)));
      chk("burst_m0_ack", 64'(m0_ack), 64'(0));
      advance();
    end
    s_ack = 1'b0;
    drive(1, 0, 0, 0, '0);
    settle(); chk("drop_s_cyc", 64'(s_cyc), 64'(0)); advance();
    settle(); chk("gap_s_cyc", 64'(s_cyc), 64'(0)); advance();
    settle(); chk("m0_gnt", 64'({s_cyc, s_adr}), 64'({1'b1, A0})); advance();
    drive(0, 0, 0, 0, '0);
    step(); step();

    // Slave never acks: timeout reported on stb cycle 16.
    base = irq_cnt;
    drive(0, 1, 1, 0, A0);
    step();
    for (int k = 0; k < TCYC; k++) step();
    drive(0, 0, 0, 0, '0);
    settle();
    chk("tmo_ack", 64'(m0_ack), 64'(1));
    chk("tmo_err", 64'(m0_err), 64'(1));
    chk("tmo_dat", 64'(m0_rdat), 64'(ERR));
    chk("tmo_irq", 64'(irq), 64'(1));
    chk("tmo_s_cyc", 64'(s_cyc), 64'(0));
    advance();
    step(); step();
    chk("irq_once", 64'(irq_cnt - base), 64'(1));

    // Asynchronous reset in the middle of an m1 transfer.
    drive(1, 1, 1, 1, A1);
    step();
    settle(); chk("pre_rst_gnt", 64'(s_cyc), 64'(1));
    #2 rst = 1'b1;
    #1 chk("async_rst", 64'(outs_any()), 64'(0));
    advance();
    drive(0, 1, 1, 0, A0);
    step();
    rst = 1'b0;
    step();
    settle(); chk("post_rst_tie", 64'(s_adr), 64'(A0)); advance();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    step(); step();

    // Random traffic, with stretches of a dead slave and occasional resets.
    repeat (1500) begin
      if ($urandom_range(39) == 0) dead = !dead;
      rst = ($urandom_range(299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!m_cyc[n]) begin
          if ($urandom_range(2) == 0) begin
            m_cyc[n]  = 1'b1;
            m_stb[n]  = 1'b1;
            m_we[n]   = 1'($urandom_range(1));
            m_sel[n]  = 4'($urandom);
            m_adr[n]  = $urandom;
            m_wdat[n] = $urandom;
          end
        end else if (!dead && $urandom_range(7) == 0) begin
          m_cyc[n] = 1'b0;
          m_stb[n] = 1'b0;
        end else begin
          m_stb[n] = dead || ($urandom_range(3) != 0);
          if (m_stb[n]) m_adr[n] = m_adr[n] + 32'd4;
        end
      end
      s_ack  = !dead && ($urandom_range(1) == 1);
      s_rdat = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
